// File: rtl/demux.sv
// Two-destination demux with one-word holding registers per output.
// Ports: clk, reset, in_* (upstream), out_a*/out_b* (downstream), cnt_a/cnt_b.
module demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             av_q, av_d;
  logic             bv_q, bv_d;
  logic [7:0]       ca_q, ca_d;
  logic [7:0]       cb_q, cb_d;

  logic acc, ld_a, ld_b, dr_a, dr_b;

  // A slot can take a word if empty or draining this same edge.
  assign in_ready = !reset &&
    (sel ? (!bv_q || out_b_ready)
         : (!av_q || out_a_ready));

  assign acc  = in_valid && in_ready;
  assign ld_a = acc && !sel;
  assign ld_b = acc && sel;
  assign dr_a = av_q && out_a_ready;
  assign dr_b = bv_q && out_b_ready;

  always_comb begin
    a_d  = ld_a ? in_data : a_q;
    b_d  = ld_b ? in_data : b_q;
    // Load wins over drain: keeps valid high with no bubble.
    av_d = ld_a || (av_q && !dr_a);
    bv_d = ld_b || (bv_q && !dr_b);
    ca_d = ca_q + {7'd0, dr_a};
    cb_d = cb_q + {7'd0, dr_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      av_q <= 1'b0;
      bv_q <= 1'b0;
      ca_q <= 8'd0;
      cb_q <= 8'd0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      av_q <= av_d;
      bv_q <= bv_d;
      ca_q <= ca_d;
      cb_q <= cb_d;
    end
  end

  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_a_valid = av_q;
  assign out_b_valid = bv_q;
  assign cnt_a       = ca_q;
  assign cnt_b       = cb_q;

endmodule

// File: tb/tb_demux.sv
// Directed self-checking bench for demux.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_demux;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       sel;
  logic       in_ready;
  logic [7:0] out_a;
  logic       out_a_valid;
  logic       out_a_ready;
  logic [7:0] out_b;
  logic       out_b_valid;
  logic       out_b_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int checks;
  int errors;

  demux #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b       (out_b),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = 8'h00;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    tick(); tick();
    checks++;
    if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got a=%b b=%b exp 0 0", out_a_valid, out_b_valid);
    end
    checks++;
    if (out_a !== 8'h00 || out_b !== 8'h00 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs got a=%h b=%h ca=%0d cb=%0d exp 0", out_a, out_b, cnt_a, cnt_b);
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_a_ready = 1'b1;
    in_data = 8'h3C; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'hEE; sel = 1'b1;
    checks++;
    if (out_a !== 8'h3C || out_a_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_load got %h/%b exp 3c/1", out_a, out_a_valid);
    end
    checks++;
    if (out_b_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_b_idle got %b exp 0", out_b_valid);
    end
    tick();
    checks++;
    if (out_a_valid !== 1'b0 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL basic_drain got v=%b cnt=%0d exp 0/1", out_a_valid, cnt_a);
    end
    checks++;
    if (out_b_valid !== 1'b0 || out_b !== 8'h00) begin
      errors++;
      $display("FAIL basic_ignore got %h/%b exp 00/0", out_b, out_b_valid);
    end
  endtask

  task automatic test_stall_b();
    out_b_ready = 1'b0;
    in_data = 8'h11; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (out_b !== 8'h11 || out_b_valid !== 1'b1 || cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL stall_hold got %h/%b cnt=%0d exp 11/1/0", out_b, out_b_valid, cnt_b);
    end
    out_b_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_b !== 8'h22 || out_b_valid !== 1'b1 || cnt_b !== 8'd1) begin
      errors++;
      $display("FAIL stall_second got %h/%b cnt=%0d exp 22/1/1", out_b, out_b_valid, cnt_b);
    end
    tick();
    checks++;
    if (out_b_valid !== 1'b0 || cnt_b !== 8'd2) begin
      errors++;
      $display("FAIL stall_done got v=%b cnt=%0d exp 0/2", out_b_valid, cnt_b);
    end
  endtask

  task automatic test_back_to_back();
    out_a_ready = 1'b0;
    in_data = 8'h5A; sel = 1'b0; in_valid = 1'b1;
    tick();
    checks++;
    if (out_a !== 8'h5A || out_a_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got %h/%b exp 5a/1", out_a, out_a_valid);
    end
    out_a_ready = 1'b1;
    in_data = 8'hA5;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_a !== 8'hA5 || out_a_valid !== 1'b1 || cnt_a !== 8'd2) begin
      errors++;
      $display("FAIL b2b_replace got %h/%b cnt=%0d exp a5/1/2", out_a, out_a_valid, cnt_a);
    end
    tick();
    checks++;
    if (out_a_valid !== 1'b0 || cnt_a !== 8'd3) begin
      errors++;
      $display("FAIL b2b_drain got v=%b cnt=%0d exp 0/3", out_a_valid, cnt_a);
    end
  endtask

  task automatic test_independent();
    out_a_ready = 1'b0;
    in_data = 8'h77; sel = 1'b0; in_valid = 1'b1;
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL indep_a_full got %b exp 0", in_ready);
    end
    out_b_ready = 1'b1;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h30 + 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL indep_b_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_b !== 8'h30 + 8'(i) || out_b_valid !== 1'b1) begin
        errors++;
        $display("FAIL indep_b_data[%0d] got %h/%b exp %h/1", i, out_b, out_b_valid, 8'h30 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_b_valid !== 1'b0 || cnt_b !== 8'd6) begin
      errors++;
      $display("FAIL indep_b_cnt got v=%b cnt=%0d exp 0/6", out_b_valid, cnt_b);
    end
    checks++;
    if (out_a !== 8'h77 || out_a_valid !== 1'b1 || cnt_a !== 8'd3) begin
      errors++;
      $display("FAIL indep_a_hold got %h/%b cnt=%0d exp 77/1/3", out_a, out_a_valid, cnt_a);
    end
  endtask

  task automatic test_wrap_and_reset();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    out_a_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick();
    end
    checks++;
    if (cnt_a !== 8'd255 || out_a !== 8'hFF || out_a_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pre got cnt=%0d %h/%b exp 255 ff/1", cnt_a, out_a, out_a_valid);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (cnt_a !== 8'd0 || out_a_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero got cnt=%0d v=%b exp 0/0", cnt_a, out_a_valid);
    end
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    in_valid = 1'b1; sel = 1'b0; in_data = 8'h01;
    tick();
    sel = 1'b1; in_data = 8'h02;
    tick();
    checks++;
    if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_full got a=%b b=%b exp 1 1", out_a_valid, out_b_valid);
    end
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    sel = 1'b0; in_data = 8'h09; reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b exp 0", in_ready);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL rst_prio got va=%b vb=%b ca=%0d cb=%0d exp 0", out_a_valid, out_b_valid, cnt_a, cnt_b);
    end
    checks++;
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got a=%h b=%h exp 00 00", out_a, out_b);
    end
    tick();
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || out_a_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got ca=%0d cb=%0d va=%b exp 0", cnt_a, cnt_b, out_a_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall_b();
    test_back_to_back();
    test_independent();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data path width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  WIDTH  word to route.
REQ-005 SHALL have port: in_valid  input  1  in_data valid.
REQ-006 SHALL have port: sel  input  1  destination; 0 = out_a, 1 = out_b.
REQ-007 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-008 SHALL have port: out_a  output  WIDTH  held word for destination A.
REQ-009 SHALL have port: out_a_valid  output  1  out_a holds a word.
REQ-010 SHALL have port: out_a_ready  input  1  consumer A takes word.
REQ-011 SHALL have ports out_b, out_b_valid, out_b_ready, identical to REQ-008..010, for destination B.
REQ-012 SHALL have ports cnt_a, cnt_b  output  8  words delivered on A / B.

Function
REQ-013 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1; sel is sampled only at acceptance.
REQ-014 SHALL load the accepted word into holding register A (sel=0) or B (sel=1); the other register is untouched.
REQ-015 SHALL set out_x_valid=1 the cycle after acceptance (1-cycle latency, registered), with out_x equal to the accepted word.
REQ-016 SHALL drive in_ready combinationally = !reset && (sel ? (!out_b_valid || out_b_ready) : (!out_a_valid || out_a_ready)).
REQ-017 SHALL complete an output handshake on a rising edge where out_x_valid=1 and out_x_ready=1; out_x_valid clears next cycle unless reloaded.
REQ-018 SHALL, on simultaneous drain and load of the same output, replace out_x with the new word and keep out_x_valid=1 (no bubble, no loss).
REQ-019 SHALL hold out_x and out_x_valid stable while out_x_valid=1 and out_x_ready=0.
REQ-020 SHALL allow both outputs to drain in the same cycle, independently of input activity.
REQ-021 SHALL ignore in_data and sel when no acceptance occurs; out_x_ready while out_x_valid=0 has no effect.
REQ-022 SHALL increment cnt_x by 1 on each output-x handshake, wrapping 255 -> 0; no saturation.
REQ-023 SHALL never drop, duplicate or reorder words per destination; per-destination order equals acceptance order.

Reset
REQ-024 SHALL, while reset=1 at a rising edge, clear out_a, out_b to 0, out_a_valid, out_b_valid to 0, cnt_a, cnt_b to 0.
REQ-025 SHALL give reset priority over any simultaneous acceptance or drain; held words are discarded and not counted.
REQ-026 SHALL hold in_ready=0 while reset=1 and release it in the first cycle with reset=0.

Verification
REQ-027 SHALL cover: reset, then in_data=8'h3C, sel=0, in_valid=1 for one cycle, out_a_ready=1 -> out_a=8'h3C, out_a_valid=1 the next cycle, cnt_a=1 after drain, out_b_valid stays 0.
REQ-028 SHALL cover: out_b_ready=0, send 8'h11 then 8'h22 to B -> second word stalls with in_ready=0, out_b stays 8'h11; raise out_b_ready -> 8'h22 follows, cnt_b=2.
REQ-029 SHALL cover: out_a_valid=1 with out_a_ready=1 and new word 8'hA5 to A in the same cycle -> out_a=8'hA5 next cycle, out_a_valid continuous, cnt_a+1.
REQ-030 SHALL cover: A stalled (out_a_ready=0, full) while words are sent to B -> B traffic flows at one word per cycle, unaffected.
REQ-031 SHALL cover: 256 drains on A -> cnt_a wraps to 0; reset asserted with both outputs full -> next cycle both valids 0, counters 0, no extra handshake.
